// File: rtl/qs_pkg.sv
// Shared types for the quicksort pending-range stack controller.
package qs_pkg;

    localparam int unsigned QS_AW = 16;

    // One stack word: {hi, lo}
    typedef struct packed {
        logic [QS_AW-1:0] hi;
        logic [QS_AW-1:0] lo;
    } range_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_POPW,
        ST_DONE
    } qs_stk_ctl_st_t;

endpackage

// File: rtl/qs_srt_stack_ctl.sv
// Pending-range scheduler for qs_srt_stack: packs {hi, lo} pushes, pops ranges to the
// sort sequencer over valid/ready across the stack's read latency, and signals completion.
module qs_srt_stack_ctl
    import qs_pkg::*;
#(
    parameter int unsigned N  = 16,
    parameter int unsigned AW = QS_AW,
    parameter int unsigned W  = 2 * AW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start_vld,
    input  logic [AW-1:0] start_lo,
    input  logic [AW-1:0] start_hi,
    output logic          start_rdy,
    input  logic          push_vld,
    input  logic [AW-1:0] push_lo,
    input  logic [AW-1:0] push_hi,
    output logic          push_rdy,
    output logic          pop_vld,
    output logic [AW-1:0] pop_lo,
    output logic [AW-1:0] pop_hi,
    input  logic          pop_rdy,
    input  logic          busy,
    output logic          done_r,
    output logic          err_r,
    output logic          stk_cmd_vld_r,
    output logic          stk_cmd_push_r,
    output logic [W-1:0]  stk_cmd_push_dat_r,
    output logic          stk_cmd_clr_r,
    input  logic [W-1:0]  stk_head_r,
    input  logic          stk_head_vld_r,
    input  logic          stk_cmd_err_w,
    input  logic          stk_empty_w,
    input  logic          stk_full_w
);

    localparam int unsigned CW = $clog2(N + 1);

    qs_stk_ctl_st_t state, state_d;
    logic [CW-1:0]  cnt, cnt_d;
    logic [CW-1:0]  stk_view;
    logic           pop_vld_d;
    logic [AW-1:0]  pop_lo_d, pop_hi_d;
    logic           cmd_vld_d, cmd_push_d;
    logic [W-1:0]   cmd_dat_d;
    logic           err_d;
    logic           push_acc, push_wr, pop_take, flag_err;

    assign start_rdy     = (state == ST_IDLE);
    assign push_rdy      = ((state == ST_RUN) || (state == ST_POPW)) && (cnt < CW'(N));
    assign push_acc      = push_vld && push_rdy;
    assign push_wr       = push_acc && (push_lo < push_hi);
    assign pop_take      = pop_vld && pop_rdy;
    assign stk_cmd_clr_r = 1'b0;

    // Occupancy the stack should report now: cnt minus the command still in flight
    always_comb begin
        stk_view = cnt;
        if (stk_cmd_vld_r && stk_cmd_push_r) begin
            stk_view = cnt - CW'(1);
        end else if (stk_cmd_vld_r) begin
            stk_view = cnt + CW'(1);
        end
    end

    assign flag_err = (state != ST_IDLE) &&
                      (((stk_view == '0) != stk_empty_w) || ((stk_view == CW'(N)) != stk_full_w));

    // Next-state, stack command and output-slot logic
    always_comb begin
        state_d    = state;
        cnt_d      = cnt;
        pop_vld_d  = pop_vld;
        pop_lo_d   = pop_lo;
        pop_hi_d   = pop_hi;
        cmd_vld_d  = 1'b0;
        cmd_push_d = 1'b0;
        cmd_dat_d  = stk_cmd_push_dat_r;
        err_d      = err_r || stk_cmd_err_w || flag_err;

        if (pop_take) begin
            pop_vld_d = 1'b0;
        end

        unique case (state)
            ST_IDLE: begin
                if (start_vld) begin
                    err_d = 1'b0;
                    if (start_lo < start_hi) begin
                        cmd_vld_d  = 1'b1;
                        cmd_push_d = 1'b1;
                        cmd_dat_d  = {start_hi, start_lo};
                        cnt_d      = cnt + CW'(1);
                        state_d    = ST_RUN;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_RUN: begin
                if (push_wr) begin
                    cmd_vld_d  = 1'b1;
                    cmd_push_d = 1'b1;
                    cmd_dat_d  = {push_hi, push_lo};
                    cnt_d      = cnt + CW'(1);
                end else if (!push_acc && (cnt != '0) && !pop_vld) begin
                    cmd_vld_d = 1'b1;
                    cnt_d     = cnt - CW'(1);
                    state_d   = ST_POPW;
                end else if (!push_acc && (cnt == '0) && !pop_vld && !busy && !push_vld) begin
                    state_d = ST_DONE;
                end
            end
            ST_POPW: begin
                if (push_wr) begin
                    cmd_vld_d  = 1'b1;
                    cmd_push_d = 1'b1;
                    cmd_dat_d  = {push_hi, push_lo};
                    cnt_d      = cnt + CW'(1);
                end
                if (stk_head_vld_r) begin
                    pop_vld_d = 1'b1;
                    pop_lo_d  = stk_head_r[AW-1:0];
                    pop_hi_d  = stk_head_r[W-1:AW];
                    state_d   = ST_RUN;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state              <= ST_IDLE;
            cnt                <= '0;
            pop_vld            <= 1'b0;
            pop_lo             <= '0;
            pop_hi             <= '0;
            stk_cmd_vld_r      <= 1'b0;
            stk_cmd_push_r     <= 1'b0;
            stk_cmd_push_dat_r <= '0;
            done_r             <= 1'b0;
            err_r              <= 1'b0;
        end else begin
            state              <= state_d;
            cnt                <= cnt_d;
            pop_vld            <= pop_vld_d;
            pop_lo             <= pop_lo_d;
            pop_hi             <= pop_hi_d;
            stk_cmd_vld_r      <= cmd_vld_d;
            stk_cmd_push_r     <= cmd_push_d;
            stk_cmd_push_dat_r <= cmd_dat_d;
            done_r             <= (state_d == ST_DONE);
            err_r              <= err_d;
        end
    end

endmodule

// File: tb/tb_qs_srt_stack_ctl.sv
// Directed bench for qs_srt_stack_ctl with a behavioural two-cycle-latency stack model.
module tb_qs_srt_stack_ctl;
    import qs_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_vld, push_vld, pop_rdy, busy;
    logic [15:0] start_lo, start_hi, push_lo, push_hi;
    logic        start_rdy, push_rdy, pop_vld, done_r, err_r;
    logic [15:0] pop_lo, pop_hi;
    logic        stk_cmd_vld_r, stk_cmd_push_r, stk_cmd_clr_r;
    logic [31:0] stk_cmd_push_dat_r;
    logic [31:0] stk_head_r;
    logic        stk_head_vld_r;
    logic        stk_cmd_err_w, stk_empty_w, stk_full_w;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    qs_srt_stack_ctl dut (
        .clk(clk), .rst(rst),
        .start_vld(start_vld), .start_lo(start_lo), .start_hi(start_hi), .start_rdy(start_rdy),
        .push_vld(push_vld), .push_lo(push_lo), .push_hi(push_hi), .push_rdy(push_rdy),
        .pop_vld(pop_vld), .pop_lo(pop_lo), .pop_hi(pop_hi), .pop_rdy(pop_rdy),
        .busy(busy), .done_r(done_r), .err_r(err_r),
        .stk_cmd_vld_r(stk_cmd_vld_r), .stk_cmd_push_r(stk_cmd_push_r),
        .stk_cmd_push_dat_r(stk_cmd_push_dat_r), .stk_cmd_clr_r(stk_cmd_clr_r),
        .stk_head_r(stk_head_r), .stk_head_vld_r(stk_head_vld_r),
        .stk_cmd_err_w(stk_cmd_err_w), .stk_empty_w(stk_empty_w), .stk_full_w(stk_full_w)
    );

    // Behavioural stack: command at cycle c, head valid at c+2
    range_t      mem [16];
    logic [4:0]  sp;
    logic        d1;
    logic [31:0] d1_dat;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            sp             <= '0;
            d1             <= 1'b0;
            d1_dat         <= '0;
            stk_head_vld_r <= 1'b0;
            stk_head_r     <= '0;
        end else begin
            d1 <= 1'b0;
            if (stk_cmd_vld_r && stk_cmd_push_r) begin
                if (sp < 5'd16) begin
                    mem[4'(sp)] <= stk_cmd_push_dat_r;
                    sp          <= sp + 5'd1;
                end
            end else if (stk_cmd_vld_r && (sp != '0)) begin
                d1     <= 1'b1;
                d1_dat <= mem[4'(sp - 5'd1)];
                sp     <= sp - 5'd1;
            end
            stk_head_vld_r <= d1;
            if (d1) stk_head_r <= d1_dat;
        end
    end

    assign stk_empty_w = (sp == 5'd0);
    assign stk_full_w  = (sp == 5'd16);

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic get_pop(input string tag, input logic [15:0] lo, input logic [15:0] hi);
        int n = 0;
        pop_rdy = 1'b1;
        while (!pop_vld && n < 30) begin
            tick();
            n++;
        end
        check({tag, "_vld"}, 32'(pop_vld), 1);
        check({tag, "_lo"}, 32'(pop_lo), 32'(lo));
        check({tag, "_hi"}, 32'(pop_hi), 32'(hi));
        tick();
    endtask

    task automatic push_one(input logic [15:0] lo, input logic [15:0] hi);
        int n = 0;
        push_vld = 1'b1;
        push_lo  = lo;
        push_hi  = hi;
        while (!push_rdy && n < 30) begin
            tick();
            n++;
        end
        check("push_rdy_wait", 32'(push_rdy), 1);
        tick();
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (!done_r && n < 40) begin
            tick();
            n++;
        end
        check(tag, 32'(done_r), 1);
        tick();
    endtask

    task automatic start_range(input logic [15:0] lo, input logic [15:0] hi);
        start_vld = 1'b1;
        start_lo  = lo;
        start_hi  = hi;
        tick();
        start_vld = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        start_vld = 1'b0; start_lo = '0; start_hi = '0;
        push_vld = 1'b0; push_lo = '0; push_hi = '0;
        pop_rdy = 1'b0; busy = 1'b0; stk_cmd_err_w = 1'b0;
        tick(); tick();
        rst = 1'b0;
        tick();

        // Reset values
        check("rst_start_rdy", 32'(start_rdy), 1);
        check("rst_push_rdy", 32'(push_rdy), 0);
        check("rst_pop_vld", 32'(pop_vld), 0);
        check("rst_pop_lo", 32'(pop_lo), 0);
        check("rst_cmd_vld", 32'(stk_cmd_vld_r), 0);
        check("rst_done", 32'(done_r), 0);
        check("rst_err", 32'(err_r), 0);
        check("rst_clr", 32'(stk_cmd_clr_r), 0);

        // Degenerate start goes straight to DONE
        start_range(16'd0, 16'd0);
        check("deg_done", 32'(done_r), 1);
        check("deg_no_cmd", 32'(stk_cmd_vld_r), 0);
        tick();
        check("deg_done_pulse", 32'(done_r), 0);
        check("deg_idle", 32'(start_rdy), 1);

        // Single range: pop latency and completion
        busy = 1'b0; pop_rdy = 1'b1;
        start_range(16'd0, 16'd15);
        check("s_push_cmd", 32'(stk_cmd_vld_r & stk_cmd_push_r), 1);
        check("s_push_dat", stk_cmd_push_dat_r, 32'h000F_0000);
        tick();
        check("s_pop_cmd_vld", 32'(stk_cmd_vld_r), 1);
        check("s_pop_cmd_push", 32'(stk_cmd_push_r), 0);
        tick(); tick();
        check("s_pop_early", 32'(pop_vld), 0);
        tick();
        check("s_pop_vld", 32'(pop_vld), 1);
        check("s_pop_lo", 32'(pop_lo), 0);
        check("s_pop_hi", 32'(pop_hi), 15);
        tick();
        check("s_pop_drop", 32'(pop_vld), 0);
        tick();
        check("s_done", 32'(done_r), 1);
        tick();

        // LIFO order, push priority over pending pop, degenerate sub-range
        busy = 1'b1; pop_rdy = 1'b0;
        start_range(16'd20, 16'd30);
        check("l_start_dat", stk_cmd_push_dat_r, 32'h001E_0014);
        push_vld = 1'b1; push_lo = 16'd0; push_hi = 16'd3;
        check("l_push_rdy", 32'(push_rdy), 1);
        tick();
        check("l_push0_dat", stk_cmd_push_dat_r, 32'h0003_0000);
        push_lo = 16'd7; push_hi = 16'd7;
        tick();
        check("l_deg_no_cmd", 32'(stk_cmd_vld_r), 0);
        push_lo = 16'd5; push_hi = 16'd9;
        tick();
        check("l_push2_dat", stk_cmd_push_dat_r, 32'h0009_0005);
        push_lo = 16'd11; push_hi = 16'd12;
        tick();
        check("l_push3_dat", stk_cmd_push_dat_r, 32'h000C_000B);
        push_vld = 1'b0;
        tick();
        check("l_pop_after_push", 32'(stk_cmd_vld_r & ~stk_cmd_push_r), 1);
        tick(); tick();
        check("l_pop_early", 32'(pop_vld), 0);
        tick();
        check("l_pop_vld", 32'(pop_vld), 1);
        tick();
        check("l_hold_vld", 32'(pop_vld), 1);
        check("l_hold_lo", 32'(pop_lo), 11);
        check("l_no_cmd_full_slot", 32'(stk_cmd_vld_r), 0);
        get_pop("l_pop0", 16'd11, 16'd12);
        get_pop("l_pop1", 16'd5, 16'd9);
        get_pop("l_pop2", 16'd0, 16'd3);
        get_pop("l_pop3", 16'd20, 16'd30);
        tick(); tick();
        check("l_busy_no_done", 32'(done_r), 0);
        busy = 1'b0;
        wait_done("l_done");

        // Fill to N, backpressure, then accept after one pop
        busy = 1'b1; pop_rdy = 1'b0;
        start_range(16'd0, 16'd1);
        for (int k = 1; k < 16; k++) begin
            push_one(16'(k), 16'(k + 1));
        end
        push_lo = 16'd1; push_hi = 16'd2;
        check("f_full_rdy", 32'(push_rdy), 0);
        tick();
        check("f_pop_issued", 32'(stk_cmd_vld_r & ~stk_cmd_push_r), 1);
        check("f_rdy_after_pop", 32'(push_rdy), 1);
        tick();
        push_vld = 1'b0;
        check("f_push_dat", stk_cmd_push_dat_r, 32'h0002_0001);
        check("f_push_cmd", 32'(stk_cmd_vld_r & stk_cmd_push_r), 1);
        check("f_err", 32'(err_r), 0);
        get_pop("f_top", 16'd15, 16'd16);
        get_pop("f_late", 16'd1, 16'd2);
        for (int k = 14; k >= 0; k--) begin
            get_pop("f_drain", 16'(k), 16'(k + 1));
        end
        check("f_err_end", 32'(err_r), 0);
        busy = 1'b0;
        wait_done("f_done");

        // Reset while waiting on the stack read
        busy = 1'b1; pop_rdy = 1'b0;
        start_range(16'd3, 16'd8);
        tick(); tick(); tick();
        rst = 1'b1;
        #1;
        check("r_start_rdy", 32'(start_rdy), 1);
        check("r_pop_vld", 32'(pop_vld), 0);
        check("r_cmd_vld", 32'(stk_cmd_vld_r), 0);
        check("r_cmd_dat", stk_cmd_push_dat_r, 0);
        check("r_push_rdy", 32'(push_rdy), 0);
        tick();
        rst = 1'b0;
        tick();
        busy = 1'b0;
        start_range(16'd2, 16'd7);
        get_pop("r_pop", 16'd2, 16'd7);
        wait_done("r_done");

        // Sticky error, cleared by the next start
        stk_cmd_err_w = 1'b1;
        tick();
        stk_cmd_err_w = 1'b0;
        check("e_set", 32'(err_r), 1);
        tick();
        check("e_sticky", 32'(err_r), 1);
        start_range(16'd0, 16'd0);
        check("e_clear", 32'(err_r), 0);
        check("e_done", 32'(done_r), 1);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
